reg_writeback_unit: RTL and testbench

//  Write-side companion of the 8x16 register file: collects ALU and memory-load results,

---
 rtl/reg_writeback_unit.sv | 151 +++++++++++++++
 tb/tb_reg_writeback_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// Write-back collector for the 8x16 register file: orders load/ALU results into a single write port.
// Optional operand forwarding is compiled in with `define WB_FORWARD_EN.
module reg_writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         alu_valid,
  input  logic [ADDR_W-1:0]            alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         wb_stall,
  output logic                         reg_write,
  output logic [ADDR_W-1:0]            write_addr,
  output logic [DATA_W-1:0]            write_data,
  output logic [$clog2(DEPTH):0]       pending,
  output logic                         overflow,
  input  logic [ADDR_W-1:0]            q_addr1,
  input  logic [ADDR_W-1:0]            q_addr2,
  output logic                         q_hit1,
  output logic                         q_hit2,
  output logic [DATA_W-1:0]            q_data1,
  output logic [DATA_W-1:0]            q_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, wr_ptr_p1;
  logic [CNT_W-1:0]  count;

  logic              mem_acc, alu_acc, pop;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              push0_valid, push1_valid;
  logic [ADDR_W-1:0] push0_addr, push1_addr;
  logic [DATA_W-1:0] push0_data, push1_data;
  logic [1:0]        n_push;

  // Stalling at DEPTH-1 leaves room for a dual-result cycle with no pop.
  assign wb_stall  = (count >= CNT_W'(DEPTH - 1));
  assign pending   = count;
  assign mem_acc   = mem_valid & ~wb_stall;
  assign alu_acc   = alu_valid & ~wb_stall;
  assign pop       = (count != '0);
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

  always_comb begin
    out_valid   = 1'b0;
    out_addr    = '0;
    out_data    = '0;
    push0_valid = 1'b0;
    push0_addr  = '0;
    push0_data  = '0;
    push1_valid = 1'b0;
    push1_addr  = alu_addr;
    push1_data  = alu_data;
    if (pop) begin
      out_valid   = 1'b1;
      out_addr    = fifo_addr[rd_ptr];
      out_data    = fifo_data[rd_ptr];
      push0_valid = mem_acc | alu_acc;
      push0_addr  = mem_acc ? mem_addr : alu_addr;
      push0_data  = mem_acc ? mem_data : alu_data;
      push1_valid = mem_acc & alu_acc;
    end else if (mem_acc) begin
      out_valid   = 1'b1;
      out_addr    = mem_addr;
      out_data    = mem_data;
      push0_valid = alu_acc;
      push0_addr  = alu_addr;
      push0_data  = alu_data;
    end else if (alu_acc) begin
      out_valid   = 1'b1;
      out_addr    = alu_addr;
      out_data    = alu_data;
    end
    n_push = {1'b0, push0_valid} + {1'b0, push1_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      overflow   <= 1'b0;
    end else begin
      count     <= count + CNT_W'(n_push) - CNT_W'(pop);
      wr_ptr    <= wr_ptr + PTR_W'(n_push);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      reg_write <= out_valid;
      if (out_valid) begin
        write_addr <= out_addr;
        write_data <= out_data;
      end
      if ((mem_valid | alu_valid) & wb_stall) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries beyond count are never observed.
  always_ff @(posedge clk) begin
    if (push0_valid) begin
      fifo_addr[wr_ptr] <= push0_addr;
      fifo_data[wr_ptr] <= push0_data;
    end
    if (push1_valid) begin
      fifo_addr[wr_ptr_p1] <= push1_addr;
      fifo_data[wr_ptr_p1] <= push1_data;
    end
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest matching write wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (reg_write && write_addr == a) r = {1'b1, write_data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && fifo_addr[idx] == a) r = {1'b1, fifo_data[idx]};
    end
    if (mem_acc && mem_addr == a) r = {1'b1, mem_data};
    if (alu_acc && alu_addr == a) r = {1'b1, alu_data};
    return r;
  endfunction

  always_comb begin
    {q_hit1, q_data1} = lookup(q_addr1);
    {q_hit2, q_data2} = lookup(q_addr2);
  end
`else
  logic unused_q;
  assign unused_q = ^{q_addr1, q_addr2};
  assign q_hit1   = 1'b0;
  assign q_hit2   = 1'b0;
  assign q_data1  = '0;
  assign q_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed self-checking bench for reg_writeback_unit (DEPTH=4); follows WB_FORWARD_EN if defined.
module tb_reg_writeback_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [2:0]  mem_addr, alu_addr, q_addr1, q_addr2;
  logic [15:0] mem_data, alu_data;
  logic        wb_stall, reg_write, overflow, q_hit1, q_hit2;
  logic [2:0]  write_addr;
  logic [15:0] write_data, q_data1, q_data2;
  logic [2:0]  pending;
  int          errors = 0;
  int          checks = 0;

  reg_writeback_unit #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .wb_stall(wb_stall), .reg_write(reg_write), .write_addr(write_addr),
    .write_data(write_data), .pending(pending), .overflow(overflow),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                       input logic av, input logic [2:0] aa, input logic [15:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    q_addr1 = 3'd0; q_addr2 = 3'd0;
    tick(); tick();
    reset = 1'b0;
    if ({reg_write, write_addr, write_data} !== 20'h0) begin
      errors++; $display("FAIL reset_out: got rw=%0b a=%0d d=%h want 0/0/0000", reg_write, write_addr, write_data);
    end
    checks++;
    if ({pending, overflow, wb_stall} !== 5'b0) begin
      errors++; $display("FAIL reset_state: got pend=%0d ovf=%0b stall=%0b want 0/0/0", pending, overflow, wb_stall);
    end
    checks++;
  endtask

  task automatic test_single_alu();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h00AA);
    tick();
    idle();
    if ({reg_write, write_addr, write_data, pending} !== {1'b1, 3'd3, 16'h00AA, 3'd0}) begin
      errors++; $display("FAIL single_write: got rw=%0b a=%0d d=%h p=%0d want 1/3/00aa/0", reg_write, write_addr, write_data, pending);
    end
    checks++;
    tick();
    if ({reg_write, pending} !== 4'b0) begin
      errors++; $display("FAIL single_after: got rw=%0b p=%0d want 0/0", reg_write, pending);
    end
    checks++;
  endtask

  task automatic test_dual();
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    tick();
    idle();
    if ({reg_write, write_addr, write_data, pending} !== {1'b1, 3'd1, 16'h1111, 3'd1}) begin
      errors++; $display("FAIL dual_first: got rw=%0b a=%0d d=%h p=%0d want 1/1/1111/1", reg_write, write_addr, write_data, pending);
    end
    checks++;
    tick();
    if ({reg_write, write_addr, write_data, pending} !== {1'b1, 3'd2, 16'h2222, 3'd0}) begin
      errors++; $display("FAIL dual_second: got rw=%0b a=%0d d=%h p=%0d want 1/2/2222/0", reg_write, write_addr, write_data, pending);
    end
    checks++;
    tick();
    if (reg_write !== 1'b0) begin
      errors++; $display("FAIL dual_idle: got rw=%0b want 0", reg_write);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ea [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd0};
    logic [15:0] ed [7] = '{16'h1000, 16'h2000, 16'h1001, 16'h2001, 16'h1002, 16'h2002, 16'h0};
    logic [2:0]  ep [7] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic        es [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ew [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      if (k < 3) drive(1'b1, 3'(k), 16'h1000 + 16'(k), 1'b1, 3'(k + 4), 16'h2000 + 16'(k));
      tick();
      idle();
      if (reg_write !== ew[k] || (ew[k] && (write_addr !== ea[k] || write_data !== ed[k]))) begin
        errors++; $display("FAIL b2b_write%0d: got rw=%0b a=%0d d=%h want %0b/%0d/%h", k, reg_write, write_addr, write_data, ew[k], ea[k], ed[k]);
      end
      checks++;
      if (pending !== ep[k] || wb_stall !== es[k]) begin
        errors++; $display("FAIL b2b_level%0d: got p=%0d stall=%0b want %0d/%0b", k, pending, wb_stall, ep[k], es[k]);
      end
      checks++;
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_overflow: got %0b want 0", overflow);
    end
    checks++;
  endtask

  task automatic test_overflow();
    int nwr = 0;
    bit dead_seen = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'(k), 16'h3000 + 16'(k), 1'b1, 3'(k + 4), 16'h4000 + 16'(k));
      tick();
      if (reg_write) begin nwr++; if (write_data === 16'hDEAD) dead_seen = 1; end
    end
    idle();
    if (wb_stall !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_prefill: got stall=%0b ovf=%0b want 1/0", wb_stall, overflow);
    end
    checks++;
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hDEAD);
    tick();
    idle();
    if (reg_write) begin nwr++; if (write_data === 16'hDEAD) dead_seen = 1; end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %0b want 1", overflow);
    end
    checks++;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (reg_write) begin nwr++; if (write_data === 16'hDEAD) dead_seen = 1; end
    end
    if (nwr != 6 || dead_seen) begin
      errors++; $display("FAIL ovf_stream: got writes=%0d dropped_seen=%0b want 6/0", nwr, dead_seen);
    end
    checks++;
    if (overflow !== 1'b1 || pending !== 3'd0) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%0b p=%0d want 1/0", overflow, pending);
    end
    checks++;
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'(k), 16'h5000 + 16'(k), 1'b1, 3'(k + 4), 16'h6000 + 16'(k));
      tick();
    end
    idle();
    if (pending !== 3'd3) begin
      errors++; $display("FAIL rst_prefill: got p=%0d want 3", pending);
    end
    checks++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if ({pending, reg_write, overflow, wb_stall} !== 6'b0) begin
      errors++; $display("FAIL rst_mid: got p=%0d rw=%0b ovf=%0b stall=%0b want 0/0/0/0", pending, reg_write, overflow, wb_stall);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (reg_write !== 1'b0 || pending !== 3'd0) begin
        errors++; $display("FAIL rst_stale%0d: got rw=%0b p=%0d want 0/0", k, reg_write, pending);
      end
      checks++;
    end
  endtask

  task automatic test_forward();
    drive(1'b1, 3'd4, 16'h0044, 1'b1, 3'd5, 16'h0001);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h0002);
    q_addr1 = 3'd5; q_addr2 = 3'd6;
    #1;
`ifdef WB_FORWARD_EN
    if (q_hit1 !== 1'b1 || q_data1 !== 16'h0002) begin
      errors++; $display("FAIL fwd_youngest: got hit=%0b d=%h want 1/0002", q_hit1, q_data1);
    end
    checks++;
    if (q_hit2 !== 1'b0) begin
      errors++; $display("FAIL fwd_miss: got hit=%0b want 0", q_hit2);
    end
    checks++;
    q_addr2 = 3'd4;
    alu_valid = 1'b0;
    #1;
    if (q_hit1 !== 1'b1 || q_data1 !== 16'h0001) begin
      errors++; $display("FAIL fwd_fifo: got hit=%0b d=%h want 1/0001", q_hit1, q_data1);
    end
    checks++;
    if (q_hit2 !== 1'b1 || q_data2 !== 16'h0044) begin
      errors++; $display("FAIL fwd_outreg: got hit=%0b d=%h want 1/0044", q_hit2, q_data2);
    end
    checks++;
    alu_valid = 1'b1;
`else
    if (q_hit1 !== 1'b0 || q_data1 !== 16'h0 || q_hit2 !== 1'b0) begin
      errors++; $display("FAIL fwd_disabled: got hit1=%0b d1=%h hit2=%0b want 0/0000/0", q_hit1, q_data1, q_hit2);
    end
    checks++;
`endif
    tick();
    idle();
    q_addr1 = 3'd0; q_addr2 = 3'd0;
    if ({reg_write, write_addr, write_data} !== {1'b1, 3'd5, 16'h0001}) begin
      errors++; $display("FAIL fwd_order1: got rw=%0b a=%0d d=%h want 1/5/0001", reg_write, write_addr, write_data);
    end
    checks++;
    tick();
    if ({reg_write, write_addr, write_data} !== {1'b1, 3'd5, 16'h0002}) begin
      errors++; $display("FAIL fwd_order2: got rw=%0b a=%0d d=%h want 1/5/0002", reg_write, write_addr, write_data);
    end
    checks++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual();
    test_back_to_back();
    test_overflow();
    test_reset_mid_drain();
    test_forward();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
